// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and default bit timing.
// A future uart_tx imports this package too.
package uart_rx_pkg;

  localparam int unsigned UartDataBits = 8;
  localparam int unsigned UartIdxW     = $clog2(UartDataBits);

  // 39.75 MHz core clock from the PLL, 115200 baud.
  localparam int unsigned UartClksPerBit = 345;

  typedef enum logic [2:0] {
    UartIdle  = 3'd0,
    UartStart = 3'd1,
    UartData  = 3'd2,
    UartStop  = 3'd3,
    UartBreak = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line does not look like an edge.
module uart_rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_core,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register, valid/ready delivery,
// sticky framing/overrun flags and an active-low flow-control output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clear,
  output logic       rts_n
);

  localparam logic [CNT_W-1:0]    BitReload  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    HalfReload = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UartIdxW-1:0] LastIdx    = UartIdxW'(UartDataBits - 1);

  logic w_rxs;

  uart_rx_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync2 (
    .clk_core (clk_core),
    .reset    (reset),
    .i_d      (rxd),
    .o_q      (w_rxs)
  );

  uart_state_e             r_state, w_state_d;
  logic [CNT_W-1:0]        r_cnt, w_cnt_d;
  logic [UartIdxW-1:0]     r_idx, w_idx_d;
  logic [UartDataBits-1:0] r_shift, w_shift_d;
  logic                    w_byte_done;
  logic                    w_frame_set;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state <= UartIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_idx_d     = r_idx;
    w_shift_d   = r_shift;
    w_byte_done = 1'b0;
    w_frame_set = 1'b0;
    unique case (r_state)
      UartIdle: begin
        if (!w_rxs) begin
          w_cnt_d   = HalfReload;
          w_state_d = UartStart;
        end
      end
      UartStart: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else if (w_rxs) begin
          // Start bit did not survive to its centre: treat as a glitch.
          w_state_d = UartIdle;
        end else begin
          w_idx_d   = '0;
          w_cnt_d   = BitReload;
          w_state_d = UartData;
        end
      end
      UartData: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_shift_d[r_idx] = w_rxs;
          w_cnt_d          = BitReload;
          if (r_idx == LastIdx) begin
            w_state_d = UartStop;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      UartStop: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else if (w_rxs) begin
          w_byte_done = 1'b1;
          w_state_d   = UartIdle;
        end else begin
          w_frame_set = 1'b1;
          w_state_d   = UartBreak;
        end
      end
      UartBreak: begin
        // Hold off until the line returns high so a break is not read as start bits.
        if (w_rxs) begin
          w_state_d = UartIdle;
        end
      end
      default: w_state_d = UartIdle;
    endcase
  end

  logic [7:0] r_data, w_data_d;
  logic       r_valid, w_valid_d;
  logic       r_frame_err, w_frame_err_d;
  logic       r_overrun, w_overrun_d;
  logic       r_rts_n;
  logic       w_xfer;
  logic       w_ovr_set;

  assign w_xfer    = r_valid & rx_ready;
  assign w_ovr_set = w_byte_done & r_valid & ~w_xfer;

  always_comb begin
    w_data_d      = r_data;
    w_valid_d     = r_valid;
    w_frame_err_d = r_frame_err;
    w_overrun_d   = r_overrun;
    if (w_byte_done && (!r_valid || w_xfer)) begin
      w_data_d  = r_shift;
      w_valid_d = 1'b1;
    end else if (w_xfer) begin
      w_valid_d = 1'b0;
    end
    // A set event in the same cycle as err_clear takes priority.
    if (w_frame_set) begin
      w_frame_err_d = 1'b1;
    end else if (err_clear) begin
      w_frame_err_d = 1'b0;
    end
    if (w_ovr_set) begin
      w_overrun_d = 1'b1;
    end else if (err_clear) begin
      w_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_rts_n     <= 1'b0;
    end else begin
      r_data      <= w_data_d;
      r_valid     <= w_valid_d;
      r_frame_err <= w_frame_err_d;
      r_overrun   <= w_overrun_d;
      r_rts_n     <= w_valid_d;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rts_n     = r_rts_n;

endmodule
